// File: rtl/prco_lsu.sv
// prco_lsu: load/store and writeback stage of the PRCO core.
// Takes the ALU's ce_reg / ce_ram strobes and either writes the result to the
// register file (IDLE -> WB) or runs a req/ack RAM transaction (IDLE -> MEM -> WB).
// Optional feature macro: PRCO_LSU_TIMEOUT_EN. When it is defined, a RAM wait
// longer than TIMEOUT_CYCLES abandons the access and sets the sticky q_fault.
//
// RAM handshake: q_ram_req rises with the address, write flag and write data.
// All four are held stable until i_ram_ack is sampled high on a rising edge.
// The request drops in the cycle after that edge. i_ram_rdata is only looked
// at when i_ram_ack is high.
module prco_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ce_reg,
  input  logic        i_ce_ram,
  input  logic [4:0]  i_op,
  input  logic [15:0] i_result,
  input  logic [15:0] i_store_data,
  input  logic [2:0]  i_rd,
  output logic        q_ram_req,
  output logic        q_ram_we,
  output logic [15:0] q_ram_addr,
  output logic [15:0] q_ram_wdata,
  input  logic        i_ram_ack,
  input  logic [15:0] i_ram_rdata,
  output logic        q_reg_we,
  output logic [2:0]  q_reg_sel,
  output logic [15:0] q_reg_data,
  output logic        q_ce_fetch,
  output logic        q_busy,
  output logic        q_overrun,
  output logic        q_fault
);

  // Only SW is decoded; every other opcode on the RAM path is a read.
  localparam logic [4:0] PRCO_OP_SW = 5'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        ram_req_q, ram_req_d;
  logic        ram_we_q, ram_we_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [15:0] ram_wdata_q, ram_wdata_d;
  logic [2:0]  rd_q, rd_d;
  logic        reg_we_q, reg_we_d;
  logic [2:0]  reg_sel_q, reg_sel_d;
  logic [15:0] reg_data_q, reg_data_d;
  logic        ce_fetch_q, ce_fetch_d;
  logic        overrun_q, overrun_d;
`ifdef PRCO_LSU_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = TIMEOUT_CYCLES[7:0];
  logic [7:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
`endif

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rd_d        = rd_q;
    reg_we_d    = 1'b0;
    reg_sel_d   = reg_sel_q;
    reg_data_d  = reg_data_q;
    ce_fetch_d  = 1'b0;
    overrun_d   = overrun_q;
`ifdef PRCO_LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
    fault_d     = fault_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_ce_ram) begin
          // RAM path wins a simultaneous strobe; the reg strobe is lost.
          state_d     = ST_MEM;
          ram_req_d   = 1'b1;
          ram_we_d    = (i_op == PRCO_OP_SW);
          ram_addr_d  = i_result;
          ram_wdata_d = i_store_data;
          rd_d        = i_rd;
          if (i_ce_reg) overrun_d = 1'b1;
`ifdef PRCO_LSU_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
        end else if (i_ce_reg) begin
          state_d    = ST_WB;
          reg_we_d   = 1'b1;
          reg_sel_d  = i_rd;
          reg_data_d = i_result;
          ce_fetch_d = 1'b1;
        end
      end
      ST_MEM: begin
        if (i_ce_reg || i_ce_ram) overrun_d = 1'b1;
        if (i_ram_ack) begin
          state_d    = ST_WB;
          ram_req_d  = 1'b0;
          ce_fetch_d = 1'b1;
          if (!ram_we_q) begin
            reg_we_d   = 1'b1;
            reg_sel_d  = rd_q;
            reg_data_d = i_ram_rdata;
          end
        end
`ifdef PRCO_LSU_TIMEOUT_EN
        else if ((cnt_q + 8'd1) == TIMEOUT_LIM) begin
          state_d    = ST_WB;
          ram_req_d  = 1'b0;
          ce_fetch_d = 1'b1;
          fault_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      ST_WB: begin
        if (i_ce_reg || i_ce_ram) overrun_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 16'h0000;
      ram_wdata_q <= 16'h0000;
      rd_q        <= 3'd0;
      reg_we_q    <= 1'b0;
      reg_sel_q   <= 3'd0;
      reg_data_q  <= 16'h0000;
      ce_fetch_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef PRCO_LSU_TIMEOUT_EN
      cnt_q       <= 8'd0;
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rd_q        <= rd_d;
      reg_we_q    <= reg_we_d;
      reg_sel_q   <= reg_sel_d;
      reg_data_q  <= reg_data_d;
      ce_fetch_q  <= ce_fetch_d;
      overrun_q   <= overrun_d;
`ifdef PRCO_LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
`endif
    end
  end

  assign q_ram_req   = ram_req_q;
  assign q_ram_we    = ram_we_q;
  assign q_ram_addr  = ram_addr_q;
  assign q_ram_wdata = ram_wdata_q;
  assign q_reg_we    = reg_we_q;
  assign q_reg_sel   = reg_sel_q;
  assign q_reg_data  = reg_data_q;
  assign q_ce_fetch  = ce_fetch_q;
  assign q_busy      = (state_q != ST_IDLE);
  assign q_overrun   = overrun_q;
`ifdef PRCO_LSU_TIMEOUT_EN
  assign q_fault     = fault_q;
`else
  assign q_fault     = 1'b0;
`endif

endmodule

// File: tb/tb_prco_lsu.sv
// tb_prco_lsu: directed plus randomized bench for prco_lsu.
// Inputs are driven and outputs are sampled on the falling clock edge.
// The expected register writes are kept as a queue of {sel, data} entries.
module tb_prco_lsu;

  localparam logic [4:0] OP_LW = 5'd10;
  localparam logic [4:0] OP_SW = 5'd11;

  logic        i_clk, i_rst_n;
  logic        i_ce_reg, i_ce_ram;
  logic [4:0]  i_op;
  logic [15:0] i_result, i_store_data;
  logic [2:0]  i_rd;
  logic        q_ram_req, q_ram_we;
  logic [15:0] q_ram_addr, q_ram_wdata;
  logic        i_ram_ack;
  logic [15:0] i_ram_rdata;
  logic        q_reg_we;
  logic [2:0]  q_reg_sel;
  logic [15:0] q_reg_data;
  logic        q_ce_fetch, q_busy, q_overrun, q_fault;

  int n_assert = 0;
  int n_fail   = 0;
  logic        exp_overrun = 1'b0;
  logic        exp_fault   = 1'b0;
  logic [18:0] exp_q[$];

`ifdef PRCO_LSU_TIMEOUT_EN
  prco_lsu #(.TIMEOUT_CYCLES(4)) dut (
`else
  prco_lsu dut (
`endif
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce_reg(i_ce_reg), .i_ce_ram(i_ce_ram),
    .i_op(i_op), .i_result(i_result), .i_store_data(i_store_data), .i_rd(i_rd),
    .q_ram_req(q_ram_req), .q_ram_we(q_ram_we), .q_ram_addr(q_ram_addr),
    .q_ram_wdata(q_ram_wdata), .i_ram_ack(i_ram_ack), .i_ram_rdata(i_ram_rdata),
    .q_reg_we(q_reg_we), .q_reg_sel(q_reg_sel), .q_reg_data(q_reg_data),
    .q_ce_fetch(q_ce_fetch), .q_busy(q_busy), .q_overrun(q_overrun), .q_fault(q_fault)
  );

  // Clock and watchdog
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".busy"},    {15'd0, q_busy},     16'd0);
    chk({tag, ".reg_we"},  {15'd0, q_reg_we},   16'd0);
    chk({tag, ".fetch"},   {15'd0, q_ce_fetch}, 16'd0);
    chk({tag, ".req"},     {15'd0, q_ram_req},  16'd0);
    chk({tag, ".overrun"}, {15'd0, q_overrun},  {15'd0, exp_overrun});
    chk({tag, ".fault"},   {15'd0, q_fault},    {15'd0, exp_fault});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".req"},   {15'd0, q_ram_req}, 16'd0);
    chk({tag, ".we"},    {15'd0, q_ram_we},  16'd0);
    chk({tag, ".addr"},  q_ram_addr,         16'd0);
    chk({tag, ".wdata"}, q_ram_wdata,        16'd0);
    chk({tag, ".sel"},   {13'd0, q_reg_sel}, 16'd0);
    chk({tag, ".data"},  q_reg_data,         16'd0);
    check_idle(tag);
  endtask

  // Retire cycle: fetch pulse, optional register write from the scoreboard,
  // then one cycle later the unit is idle again.
  task automatic check_retire(input string tag, input logic exp_we);
    logic [18:0] e;
    chk({tag, ".fetch"},  {15'd0, q_ce_fetch}, 16'd1);
    chk({tag, ".busy"},   {15'd0, q_busy},     16'd1);
    chk({tag, ".req"},    {15'd0, q_ram_req},  16'd0);
    chk({tag, ".reg_we"}, {15'd0, q_reg_we},   {15'd0, exp_we});
    if (q_reg_we) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".unexpected_write"}, 16'd1, 16'd0);
      end else begin
        e = exp_q.pop_front();
        chk({tag, ".sel"},  {13'd0, q_reg_sel}, {13'd0, e[18:16]});
        chk({tag, ".data"}, q_reg_data,         e[15:0]);
      end
    end
  endtask

  task automatic do_reg(input string tag, input logic [2:0] rd, input logic [15:0] res,
                        input logic stray_wb);
    i_ce_reg = 1'b1; i_rd = rd; i_result = res;
    exp_q.push_back({rd, res});
    @(negedge i_clk);
    i_ce_reg = 1'b0; i_result = 16'($urandom); i_rd = 3'($urandom);
    check_retire(tag, 1'b1);
    if (stray_wb) begin
      i_ce_ram = 1'b1;
      exp_overrun = 1'b1;
    end
    @(negedge i_clk);
    i_ce_ram = 1'b0;
    check_idle({tag, ".after"});
  endtask

  task automatic do_ram(input string tag, input logic [4:0] op, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] rdata,
                        input logic [2:0] rd, input int delay,
                        input logic stray_mem, input logic both);
    logic we;
    we = (op == OP_SW);
    i_ce_ram = 1'b1; i_ce_reg = both; i_op = op; i_result = addr;
    i_store_data = wdata; i_rd = rd;
    if (both) exp_overrun = 1'b1;
    @(negedge i_clk);
    i_ce_ram = 1'b0; i_ce_reg = 1'b0;
    i_op = 5'($urandom); i_result = 16'($urandom);
    i_store_data = 16'($urandom); i_rd = 3'($urandom);
    chk({tag, ".req"},   {15'd0, q_ram_req}, 16'd1);
    chk({tag, ".we"},    {15'd0, q_ram_we},  {15'd0, we});
    chk({tag, ".addr"},  q_ram_addr,         addr);
    chk({tag, ".wdata"}, q_ram_wdata,        wdata);
    chk({tag, ".busy"},  {15'd0, q_busy},    16'd1);
    for (int i = 0; i < delay; i++) begin
      if (stray_mem && i == 0) begin
        i_ce_reg = 1'b1;
        exp_overrun = 1'b1;
      end
      @(negedge i_clk);
      i_ce_reg = 1'b0;
      chk({tag, ".hold_req"},  {15'd0, q_ram_req}, 16'd1);
      chk({tag, ".hold_addr"}, q_ram_addr,         addr);
      chk({tag, ".hold_we"},   {15'd0, q_ram_we},  {15'd0, we});
      chk({tag, ".hold_wdata"}, q_ram_wdata,       wdata);
      chk({tag, ".hold_fetch"}, {15'd0, q_ce_fetch}, 16'd0);
    end
    i_ram_ack = 1'b1; i_ram_rdata = rdata;
    if (!we) exp_q.push_back({rd, rdata});
    @(negedge i_clk);
    i_ram_ack = 1'b0; i_ram_rdata = 16'($urandom);
    check_retire(tag, !we);
    chk({tag, ".overrun"}, {15'd0, q_overrun}, {15'd0, exp_overrun});
    @(negedge i_clk);
    check_idle({tag, ".after"});
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0;
    #1;
    exp_overrun = 1'b0;
    exp_fault = 1'b0;
    exp_q.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // Directed and randomized sequence
  initial begin
    i_rst_n = 1'b0; i_ce_reg = 1'b0; i_ce_ram = 1'b0; i_op = 5'd0;
    i_result = 16'd0; i_store_data = 16'd0; i_rd = 3'd0;
    i_ram_ack = 1'b0; i_ram_rdata = 16'd0;
    @(negedge i_clk);
    @(negedge i_clk);
    check_all_zero("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_idle("post_reset");

    do_reg("addi", 3'd3, 16'h1234, 1'b0);
    do_ram("lw", OP_LW, 16'h0040, 16'h5555, 16'hBEEF, 3'd5, 3, 1'b0, 1'b0);
    do_ram("sw", OP_SW, 16'h0010, 16'h00AA, 16'hDEAD, 3'd1, 0, 1'b0, 1'b0);

    // Ack while idle is ignored
    i_ram_ack = 1'b1; i_ram_rdata = 16'hCAFE;
    @(negedge i_clk);
    i_ram_ack = 1'b0;
    check_idle("stray_ack");

    do_ram("ovr_mem", OP_LW, 16'h0100, 16'h0000, 16'h7777, 3'd2, 2, 1'b1, 1'b0);
    do_ram("ovr_both", OP_SW, 16'h0200, 16'h1111, 16'h0000, 3'd6, 1, 1'b0, 1'b1);
    do_reg("ovr_wb", 3'd7, 16'h0F0F, 1'b1);

    // Reset two cycles into MEM
    i_ce_ram = 1'b1; i_op = OP_LW; i_result = 16'h0300; i_rd = 3'd4;
    @(negedge i_clk);
    i_ce_ram = 1'b0;
    @(negedge i_clk);
    chk("rst_mem.req_before", {15'd0, q_ram_req}, 16'd1);
    apply_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check_all_zero("rst_mem");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    do_reg("rst_mem.addi", 3'd2, 16'hA5A5, 1'b0);

    // Randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0)
        do_reg("rnd_reg", 3'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0));
      else
        do_ram("rnd_ram", ($urandom_range(0, 1) == 0) ? OP_SW : 5'($urandom),
               16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom),
               $urandom_range(0, 4), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 9) == 0));
    end
    chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);

    // RAM access that is never acknowledged
    apply_reset();
    i_ce_ram = 1'b1; i_op = OP_LW; i_result = 16'h0400; i_rd = 3'd1;
    @(negedge i_clk);
    i_ce_ram = 1'b0;
    chk("noack.req", {15'd0, q_ram_req}, 16'd1);
`ifdef PRCO_LSU_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("to.wait_req",   {15'd0, q_ram_req}, 16'd1);
      chk("to.wait_fault", {15'd0, q_fault},   16'd0);
    end
    @(negedge i_clk);
    check_retire("to", 1'b0);
    chk("to.fault", {15'd0, q_fault}, 16'd1);
    exp_fault = 1'b1;
    @(negedge i_clk);
    check_idle("to.after");
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      chk("noack.busy",  {15'd0, q_busy},     16'd1);
      chk("noack.fetch", {15'd0, q_ce_fetch}, 16'd0);
      chk("noack.fault", {15'd0, q_fault},    16'd0);
    end
    apply_reset();
    check_idle("noack.after_reset");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prco_lsu.md
# prco_lsu

Load/store and writeback unit of the PRCO core, sitting directly downstream of the ALU stage. It consumes the ALU's one-cycle `ce_reg`/`ce_ram` strobes and 16-bit result. It either writes the result straight into the register file, or runs a request/acknowledge transaction on the data-RAM port for `LW`/`SW` and writes the load data back. It closes the pipeline loop by pulsing a fetch-enable once each instruction has retired.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum number of cycles spent waiting for RAM acknowledge (range 1..255). Used only when `PRCO_LSU_TIMEOUT_EN` is defined.

Ports:
- `i_clk`  in  1  core clock; all state changes on its rising edge
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_ce_reg`  in  1  ALU strobe: result goes to the register file
- `i_ce_ram`  in  1  ALU strobe: result is a RAM address
- `i_op`  in  5  opcode of the retiring instruction (`PRCO_OP_*`)
- `i_result`  in  16  ALU result (writeback value or RAM address)
- `i_store_data`  in  16  register value to store for `SW`
- `i_rd`  in  3  destination register index
- `q_ram_req`  out  1  RAM request, held until acknowledged
- `q_ram_we`  out  1  1 = write (`SW`), 0 = read
- `q_ram_addr`  out  16  RAM address
- `q_ram_wdata`  out  16  RAM write data
- `i_ram_ack`  in  1  RAM acknowledge, single cycle
- `i_ram_rdata`  in  16  RAM read data, valid when `i_ram_ack`=1
- `q_reg_we`  out  1  register-file write enable, single-cycle pulse
- `q_reg_sel`  out  3  register-file write index
- `q_reg_data`  out  16  register-file write data
- `q_ce_fetch`  out  1  instruction retired, single-cycle pulse
- `q_busy`  out  1  high whenever state ≠ IDLE
- `q_overrun`  out  1  sticky: a strobe arrived while busy, or both strobes arrived together
- `q_fault`  out  1  sticky: RAM timeout (only with the macro defined; otherwise tied 0)

## Operation
- States: IDLE, MEM, WB.
- **IDLE, `i_ce_reg`=1 only:**
  - go to WB.
  - Register `q_reg_we`=1, `q_reg_sel`=`i_rd`, `q_reg_data`=`i_result`, `q_ce_fetch`=1.
- **IDLE, `i_ce_ram`=1:**
  - go to MEM.
  - Latch `q_ram_addr`=`i_result`, `q_ram_wdata`=`i_store_data`, `q_ram_we`=(`i_op`==`PRCO_OP_SW`), `q_ram_req`=1.
  - Any op other than `SW` is treated as a read.
- **Both strobes in the same cycle (IDLE):** the RAM path wins, the reg strobe is dropped, and `q_overrun` is set.
- **MEM:**
  - `q_ram_req`, `q_ram_addr`, `q_ram_wdata` and `q_ram_we` are held stable until `i_ram_ack` is sampled high.
  - On ack, go to WB and clear `q_ram_req`.
  - Read: `q_reg_we`=1, `q_reg_data`=`i_ram_rdata`, `q_reg_sel`=latched `i_rd`, `q_ce_fetch`=1.
  - Write: `q_ce_fetch`=1, `q_reg_we` stays 0.
- **WB:** lasts one cycle. Clear `q_reg_we` and `q_ce_fetch`, then return to IDLE.
- **Strobes while MEM or WB:** ignored, and `q_overrun` is set.
- **`i_ram_ack` outside MEM:** ignored, no flag.
- `q_overrun` and `q_fault` are cleared only by reset.
- No arithmetic. All data paths are 16-bit pass-through with no extension.

## Timing
- Every output resets to 0 asynchronously when `i_rst_n`=0, and the state resets to IDLE.
- Reset during MEM drops `q_ram_req` immediately. The transaction is abandoned and no writeback or fetch pulse is produced.
- Register path: strobe sampled at edge E0; `q_reg_we` and `q_ce_fetch` are high for the cycle after E0 (latency 1).
- RAM path: strobe sampled at E0; `q_ram_req` is high from E0.
  - Ack sampled at edge Ek (k ≥ 1): writeback and fetch pulse occur in the cycle after Ek, and `q_ram_req` is low in that same cycle.
  - Minimum latency is 2 cycles (ack present in the first request cycle).
- `q_busy` is combinational from the state: high from the cycle after E0 until the return to IDLE.
- The next strobe is accepted in the cycle where `q_ce_fetch` has just dropped (state IDLE).

## Configuration
- `PRCO_LSU_TIMEOUT_EN` defined:
  - An 8-bit counter resets on entry to MEM and increments each MEM cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`, go to WB: `q_ram_req`=0, `q_fault`=1, `q_ce_fetch`=1, no register write.
  - An ack arriving on the same edge as the timeout wins; the transaction completes normally and `q_fault` is not set.
- `PRCO_LSU_TIMEOUT_EN` undefined: MEM waits indefinitely, no counter exists, and `q_fault` is constant 0.

## Test plan
- **ADDI writeback:** `i_ce_reg`=1, `i_result`=16'h1234, `i_rd`=3 → next cycle `q_reg_we`=1, `q_reg_sel`=3, `q_reg_data`=16'h1234, `q_ce_fetch`=1; the cycle after, all low.
- **LW:** `i_ce_ram`, `i_op`=`PRCO_OP_LW`, `i_result`=16'h0040; ack after 3 cycles with `i_ram_rdata`=16'hBEEF → `q_ram_addr`=16'h0040 and `q_ram_we`=0 stable throughout; then `q_reg_data`=16'hBEEF, `q_ce_fetch`=1.
- **SW:** `i_op`=`PRCO_OP_SW`, `i_result`=16'h0010, `i_store_data`=16'h00AA, ack in the first cycle → `q_ram_we`=1, `q_ram_wdata`=16'h00AA; fetch pulse 2 cycles after the strobe; `q_reg_we` never asserts.
- **Overrun:** `i_ce_reg` pulsed while in MEM, and separately both strobes pulsed together in IDLE → `q_overrun`=1 and stays 1; the in-flight RAM transaction completes unaffected.
- **Reset mid-MEM:** deassert `i_rst_n` two cycles into MEM → `q_ram_req`=0 immediately, all outputs 0; after release, a new `i_ce_reg` works with latency 1.
- **Timeout (macro on, `TIMEOUT_CYCLES`=4):** no ack → `q_fault`=1 and `q_ce_fetch` pulse after 4 MEM cycles, no register write. With the macro off, the same stimulus leaves `q_busy`=1 indefinitely.
